// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// the default operand width.
package serial_adder_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// One-bit full-adder cell (module full_adder_cell): two half-adder stages
// whose carries are merged by an OR. Purely combinational.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    logic ha1_sum_s;
    logic ha1_carry_s;
    logic ha2_carry_s;

    // First half adder combines the operand bits.
    assign ha1_sum_s   = a ^ b;
    assign ha1_carry_s = a & b;

    // Second half adder folds in the incoming carry.
    assign sum         = ha1_sum_s ^ cin;
    assign ha2_carry_s = ha1_sum_s & cin;

    // Only one of the half-adder carries can be set at a time.
    assign carry       = ha1_carry_s | ha2_carry_s;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: a single full-adder cell processes the
// operands LSB first over WIDTH cycles (IDLE -> SHIFT x WIDTH -> DONE).
// Optional build macro SERIAL_ADDER_OVF_EN adds a signed-overflow output ovf.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   sum_r;
    logic               carry_r;
    logic               busy_r;
    logic               done_r;
    logic               accept_s;
    logic               last_s;
    logic               fa_sum_s;
    logic               fa_carry_s;

    // The single adder cell always looks at the current LSBs and carry.
    full_adder_cell u_fa (
        .a     (a_r[0]),
        .b     (b_r[0]),
        .cin   (carry_r),
        .sum   (fa_sum_s),
        .carry (fa_carry_s)
    );

    assign last_s = (cnt_r == CNT_LAST);

    // Next-state logic; DONE accepts a new start exactly like IDLE.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_s  = SHIFT;
                    accept_s = 1'b1;
                end else begin
                    state_s  = IDLE;
                end
            end
            SHIFT: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, status flags, operand capture and the serial add datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == SHIFT);
            done_r  <= (state_s == DONE);
            if (accept_s) begin
                a_r     <= a;
                b_r     <= b;
                carry_r <= cin;
                cnt_r   <= {CNT_W{1'b0}};
            end else if (state_r == SHIFT) begin
                a_r     <= {1'b0, a_r[WIDTH-1:1]};
                b_r     <= {1'b0, b_r[WIDTH-1:1]};
                sum_r   <= {fa_sum_s, sum_r[WIDTH-1:1]};
                carry_r <= fa_carry_s;
                cnt_r   <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r   <= cnt_r;
            end
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign sum   = sum_r;
    assign carry = carry_r;

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_r;

    // On the MSB step carry_r is the carry into the MSB; compare with carry out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if ((state_r == SHIFT) && last_s) begin
            ovf_r <= carry_r ^ fa_carry_s;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int n_run;
    int n_fail;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .carry (carry)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one addition starting from a low clock phase; start is accepted
    // on the next rising edge (cycle 0). Inputs are scrambled after capture.
    task automatic run_op(input string name, input logic [7:0] av,
                          input logic [7:0] bv, input logic ci);
        logic [8:0] full;
        full = {1'b0, av} + {1'b0, bv} + {8'd0, ci};
        a = av; b = bv; cin = ci; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; a = ~av; b = ~bv; cin = ~ci;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            n_run++;
            if (busy !== (k <= 8)) begin
                n_fail++;
                $display("FAIL %s busy cycle %0d: got %b want %b", name, k, busy, (k <= 8));
            end
            n_run++;
            if (done !== (k == 9)) begin
                n_fail++;
                $display("FAIL %s done cycle %0d: got %b want %b", name, k, done, (k == 9));
            end
            if (k >= 9) begin
                n_run++;
                if ({carry, sum} !== full) begin
                    n_fail++;
                    $display("FAIL %s result cycle %0d: got %h/%h want %h/%h", name, k, carry, sum, full[8], full[7:0]);
                end
`ifdef SERIAL_ADDER_OVF_EN
                n_run++;
                if (ovf !== ((av[7] == bv[7]) && (full[7] != av[7]))) begin
                    n_fail++;
                    $display("FAIL %s ovf cycle %0d: got %b want %b", name, k, ovf, ((av[7] == bv[7]) && (full[7] != av[7])));
                end
`endif
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
        repeat (3) @(negedge clk);
        n_run++;
        if ({busy, done, carry, sum} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b carry=%b sum=%h want all 0", busy, done, carry, sum);
        end
`ifdef SERIAL_ADDER_OVF_EN
        n_run++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ovf: got %b want 0", ovf);
        end
`endif
        #1 rst_n = 1'b1;
        // start presented immediately: must be taken on the first edge after release
        run_op("first_after_reset", 8'h12, 8'h34, 1'b0);
    endtask

    task automatic test_ripple();
        run_op("ripple", 8'hFF, 8'h01, 1'b0);
    endtask

    task automatic test_cin();
        run_op("cin", 8'h3C, 8'h5A, 1'b1);
        run_op("neg_ovf", 8'h80, 8'h80, 1'b0);
        run_op("zero", 8'h00, 8'h00, 1'b0);
        run_op("all_ones", 8'hFF, 8'hFF, 1'b1);
    endtask

    task automatic test_ignore_start();
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            n_run++;
            if (done !== (k == 9)) begin
                n_fail++;
                $display("FAIL ignore_done cycle %0d: got %b want %b", k, done, (k == 9));
            end
            if (k == 9) begin
                n_run++;
                if ({carry, sum} !== 9'h002) begin
                    n_fail++;
                    $display("FAIL ignore_result: got %h/%h want 0/02", carry, sum);
                end
            end
            if (k == 3) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        a = 8'hF0; b = 8'h20; cin = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            n_run++;
            if (busy !== (((k >= 1) && (k <= 8)) || ((k >= 10) && (k <= 17)))) begin
                n_fail++;
                $display("FAIL b2b_busy cycle %0d: got %b", k, busy);
            end
            n_run++;
            if (done !== ((k == 9) || (k == 18))) begin
                n_fail++;
                $display("FAIL b2b_done cycle %0d: got %b", k, done);
            end
            if (k == 9) begin
                n_run++;
                if ({carry, sum} !== 9'h030) begin
                    n_fail++;
                    $display("FAIL b2b_first: got %h/%h want 0/30", carry, sum);
                end
            end
            if (k == 18) begin
                n_run++;
                if ({carry, sum} !== 9'h111) begin
                    n_fail++;
                    $display("FAIL b2b_second: got %h/%h want 1/11", carry, sum);
                end
            end
            if (k >= 10) start = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        a = 8'h07; b = 8'h00; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_run++;
        if ({busy, done, carry, sum} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got busy=%b done=%b carry=%b sum=%h want all 0", busy, done, carry, sum);
        end
        #1 rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            n_run++;
            if ({busy, done} !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_mid_quiet cycle %0d: got busy=%b done=%b want 0 0", k, busy, done);
            end
        end
        run_op("after_reset_mid", 8'hA5, 8'h5A, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 1000; i++) begin
            run_op("random", 8'($urandom), 8'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        n_run = 0;
        n_fail = 0;
        test_reset();
        test_ripple();
        test_cin();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
